// File: rtl/counter_load_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// counter_ctrl_pkg
// Shared definitions for the counter load arbiter:
//   ctrl_state_t   - controller states (IDLE/LOAD/RUN/DONE)
//   CNT_WIDTH      - default width of the shared up-counter
//   watchdog_limit - number of RUN cycles allowed before a run is abandoned
// ---------------------------------------------------------------------------
package counter_ctrl_pkg;

  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ctrl_state_t;

  // A legitimate run never needs more RUN cycles than the counter has values.
  function automatic int unsigned watchdog_limit(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/counter_load_arbiter_if.sv
// ---------------------------------------------------------------------------
// counter_load_arbiter_if
// Requester-side bus of the counter load arbiter.
//   req_valid/req_start/req_end : run requests (packed WIDTH slices per requester)
//   req_ready                   : one-hot accept pulse
//   abort                       : terminates the active run
//   done/err                    : one-hot completion pulse and its error qualifier
//   busy                        : a run is in progress
// master = requesters, slave = arbiter.
// ---------------------------------------------------------------------------
interface counter_load_arbiter_if
  import counter_ctrl_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = CNT_WIDTH
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_start;
  logic [NREQ*WIDTH-1:0] req_end;
  logic [NREQ-1:0]       req_ready;
  logic                  abort;
  logic [NREQ-1:0]       done;
  logic                  err;
  logic                  busy;

  modport master (
    output req_valid, req_start, req_end, abort,
    input  req_ready, done, err, busy
  );

  modport slave (
    input  req_valid, req_start, req_end, abort,
    output req_ready, done, err, busy
  );

endinterface

// File: rtl/counter_load_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter.
//   req         : request vector
//   last_grant  : index of the previous winner; search starts one above it
//   grant       : one-hot grant
//   grant_idx   : index of the granted requester
//   grant_valid : some requester was granted
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid
);

  // Walk the requesters in rotating order and keep the first one found.
  always_comb begin
    logic [IDXW-1:0] idx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = IDXW'((int'(last_grant) + off) % NREQ);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/counter_load_arbiter.sv
// ---------------------------------------------------------------------------
// counter_load_arbiter
// Shares one loadable up-counter between NREQ requesters. Each accepted
// request loads its start value, lets the counter run until it shows the
// end value (or abort / watchdog), then pulses done to the owner.
//   clk, reset    : clock and asynchronous active-low reset
//   bus           : requester handshake (counter_load_arbiter_if.slave)
//   cnt_load      : counter load select
//   cnt_d         : counter load value
//   cnt_q         : counter output
// ---------------------------------------------------------------------------
module counter_load_arbiter
  import counter_ctrl_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  counter_load_arbiter_if.slave  bus,
  output logic                   cnt_load,
  output logic [WIDTH-1:0]       cnt_d,
  input  logic [WIDTH-1:0]       cnt_q
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTH:0] WD_LAST = (WIDTH+1)'(watchdog_limit(WIDTH) - 1);

  ctrl_state_t     state, state_next;
  logic [IDXW-1:0] owner, last_grant, grant_idx;
  logic [NREQ-1:0] grant;
  logic            grant_valid;
  logic [WIDTH-1:0] start_r, end_r;
  logic [WIDTH:0]  wd;
  logic            err_r;
  logic            end_match, wd_expired;

  rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
    .req         (bus.req_valid),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign end_match  = (cnt_q == end_r);
  assign wd_expired = (wd == WD_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode; abort wins over an end match in the same cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (grant_valid) state_next = LOAD;
      LOAD: state_next = bus.abort ? DONE : RUN;
      RUN:  if (bus.abort || end_match || wd_expired) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Run context: owner, bounds, watchdog and the error flag reported with done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner      <= '0;
      last_grant <= IDXW'(NREQ - 1);
      start_r    <= '0;
      end_r      <= '0;
      wd         <= '0;
      err_r      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (grant_valid) begin
          owner   <= grant_idx;
          start_r <= bus.req_start[int'(grant_idx)*WIDTH +: WIDTH];
          end_r   <= bus.req_end[int'(grant_idx)*WIDTH +: WIDTH];
          err_r   <= 1'b0;
        end
        LOAD: begin
          wd    <= '0;
          err_r <= bus.abort;
        end
        RUN: begin
          if (bus.abort || end_match || wd_expired) err_r <= bus.abort || !end_match;
          else                                      wd    <= wd + 1'b1;
        end
        DONE: last_grant <= owner;
        default: ;
      endcase
    end
  end

  // req_ready is the only input-driven output; it is held low during reset.
  assign bus.req_ready = (state == IDLE && reset) ? grant : '0;
  assign bus.done      = (state == DONE) ? ({{(NREQ-1){1'b0}}, 1'b1} << owner) : '0;
  assign bus.err       = (state == DONE) && err_r;
  assign bus.busy      = (state != IDLE);
  assign cnt_load      = (state == LOAD);
  assign cnt_d         = start_r;

endmodule

// File: tb/tb_counter_load_arbiter.sv
// ---------------------------------------------------------------------------
// tb_counter_load_arbiter
// Bench for counter_load_arbiter with a behavioural 4-bit loadable counter.
// Expected completions (owner, err, cycle) are queued at accept time and
// compared when done fires.
// ---------------------------------------------------------------------------
module tb_counter_load_arbiter;

  localparam int NREQ  = 2;
  localparam int WIDTH = 4;

  typedef struct {
    int owner;
    int err;
    int cycle;
  } exp_t;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             hold  = 1'b0;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;
  int               cyc    = 0;
  int               checks = 0;
  int               errors = 0;
  exp_t             sb[$];

  counter_load_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  counter_load_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .cnt_load (cnt_load),
    .cnt_d    (cnt_d),
    .cnt_q    (cnt_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter stand-in; hold pins it at zero to starve the end match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        cnt_q <= '0;
    else if (hold)     cnt_q <= '0;
    else if (cnt_load) cnt_q <= cnt_d;
    else               cnt_q <= cnt_q + 1'b1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exclusivity holds every cycle.
  always @(negedge clk) begin
    check_output("done_onehot0", 32'($onehot0(bus.done)), 32'd1);
    check_output("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
  end

  task automatic apply_stimulus(input int idx, input logic [3:0] s, input logic [3:0] e);
    bus.req_start[idx*WIDTH +: WIDTH] = s;
    bus.req_end[idx*WIDTH +: WIDTH]   = e;
    bus.req_valid[idx]                = 1'b1;
  endtask

  task automatic wait_ready(output bit found, output int a, output int got);
    found = 1'b0;
    a     = 0;
    got   = -1;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (bus.req_ready != '0) begin
        found = 1'b1;
        a     = cyc;
        for (int j = 0; j < NREQ; j++) if (bus.req_ready[j]) got = j;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // kind: 0 = normal end match, 1 = watchdog, 2 = abort in the 2nd RUN cycle
  task automatic run_one(input int owner_exp, input logic [3:0] s, input logic [3:0] e,
                         input int kind, input bit drop);
    bit         found;
    int         a, got;
    logic [3:0] k;
    exp_t       x, y;
    wait_ready(found, a, got);
    check_output("grant_seen", 32'(found), 32'd1);
    check_output("grant_idx", got, owner_exp);
    check_output("req_ready", 32'(bus.req_ready), 32'd1 << owner_exp);
    k       = e - s;
    x.owner = owner_exp;
    x.err   = (kind != 0) ? 1 : 0;
    case (kind)
      0:       x.cycle = a + 3 + int'(k);
      1:       x.cycle = a + 18;
      default: x.cycle = a + 4;
    endcase
    sb.push_back(x);
    @(negedge clk);
    check_output("cnt_load", 32'(cnt_load), 32'd1);
    check_output("cnt_d", 32'(cnt_d), 32'(s));
    check_output("busy_load", 32'(bus.busy), 32'd1);
    if (drop) bus.req_valid[owner_exp] = 1'b0;
    if (kind == 2) begin
      @(negedge clk);
      @(negedge clk);
      bus.abort = 1'b1;
    end
    wait_done(found);
    bus.abort = 1'b0;
    check_output("done_seen", 32'(found), 32'd1);
    if (sb.size() > 0) begin
      y = sb.pop_front();
      check_output("done_vec", 32'(bus.done), 32'd1 << y.owner);
      check_output("done_err", 32'(bus.err), y.err);
      check_output("done_cycle", cyc, y.cycle);
    end
  endtask

  initial begin
    bit   found;
    int   a, got, last, nxt;
    bus.req_valid = '0;
    bus.req_start = '0;
    bus.req_end   = '0;
    bus.abort     = 1'b0;

    // Reset values
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_output("rst_ready", 32'(bus.req_ready), 0);
    check_output("rst_done", 32'(bus.done), 0);
    check_output("rst_err", 32'(bus.err), 0);
    check_output("rst_busy", 32'(bus.busy), 0);
    check_output("rst_cnt_load", 32'(cnt_load), 0);
    check_output("rst_cnt_d", 32'(cnt_d), 0);
    @(negedge clk);
    reset = 1'b1;
    $display("[TB] reset released");

    // Single run 7 -> A
    apply_stimulus(0, 4'h7, 4'hA);
    run_one(0, 4'h7, 4'hA, 0, 1'b1);
    last = 0;

    // Both requesters held valid: grants alternate
    apply_stimulus(0, 4'h1, 4'h2);
    apply_stimulus(1, 4'h3, 4'h3);
    for (int r = 0; r < 4; r++) begin
      nxt = (last + 1) % NREQ;
      if (nxt == 0) run_one(0, 4'h1, 4'h2, 0, 1'b0);
      else          run_one(1, 4'h3, 4'h3, 0, 1'b0);
      last = nxt;
    end
    bus.req_valid = '0;

    // Wrap-through run and a zero-length run
    apply_stimulus(1, 4'hE, 4'h2);
    run_one(1, 4'hE, 4'h2, 0, 1'b1);
    apply_stimulus(0, 4'h5, 4'h5);
    run_one(0, 4'h5, 4'h5, 0, 1'b1);

    // Watchdog with a starved counter
    hold = 1'b1;
    apply_stimulus(1, 4'h1, 4'h3);
    run_one(1, 4'h1, 4'h3, 1, 1'b1);
    hold = 1'b0;

    // Abort, once coinciding with an end match, then a normal run
    apply_stimulus(0, 4'h4, 4'h5);
    run_one(0, 4'h4, 4'h5, 2, 1'b1);
    apply_stimulus(1, 4'h0, 4'h9);
    run_one(1, 4'h0, 4'h9, 2, 1'b1);
    apply_stimulus(0, 4'h2, 4'h6);
    run_one(0, 4'h2, 4'h6, 0, 1'b1);

    // Reset in the middle of a run
    apply_stimulus(1, 4'h0, 4'hF);
    wait_ready(found, a, got);
    check_output("mid_grant_seen", 32'(found), 32'd1);
    check_output("mid_grant_idx", got, 1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_output("mid_busy", 32'(bus.busy), 32'd1);
    apply_stimulus(0, 4'h3, 4'h6);
    reset = 1'b0;
    #1;
    check_output("mid_rst_ready", 32'(bus.req_ready), 0);
    check_output("mid_rst_done", 32'(bus.done), 0);
    check_output("mid_rst_err", 32'(bus.err), 0);
    check_output("mid_rst_busy", 32'(bus.busy), 0);
    check_output("mid_rst_cnt_load", 32'(cnt_load), 0);
    check_output("mid_rst_cnt_d", 32'(cnt_d), 0);
    repeat (3) begin
      @(negedge clk);
      check_output("mid_rst_no_done", 32'(bus.done), 0);
    end
    reset = 1'b1;
    run_one(0, 4'h3, 4'h6, 0, 1'b1);
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    check_output("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
